// File: rtl/float_acc.sv
// ---------------------------------------------------------------------------
// float_acc
//   Streaming binary32 accumulator placed after a pipelined float multiplier.
//   A run pulse clears the sum and loads the counters. The unit then skips
//   delay0 running-cycles and adds len consecutive samples of in0 into a
//   registered sum.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   running  global enable; state, counters and sum freeze while low
//   run      single-cycle start pulse (acts even while running is low)
//   done     high in IDLE and DONE
//   delay0   cycles to skip after run before the first sample
//   len      number of samples to accumulate
//   in0      binary32 sample stream
//   out0     registered running sum (binary32)
// ---------------------------------------------------------------------------
module float_acc #(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    output logic               done,
    input  logic [DELAY_W-1:0] delay0,
    input  logic [DELAY_W-1:0] len,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] ACC   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]         state;
    logic [DELAY_W-1:0] dcnt;
    logic [DELAY_W-1:0] scnt;
    logic [31:0]        acc;

    // Round a normalised 27-bit significand (hidden bit at [26], then 23
    // fraction bits, then guard/round/sticky) to nearest-even and pack it.
    // Handles flush-to-zero on underflow and saturation to infinity.
    function automatic logic [31:0] round_pack(input logic             s,
                                               input logic signed [9:0] e,
                                               input logic [26:0]      m);
        logic [24:0]       mr;
        logic              up;
        logic signed [9:0] er;
        logic [31:0]       r;
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[26:3]} + {24'b0, up};
        er = e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 10'sd1;
        end
        if (m == 27'd0 || e <= 10'sd0)
            r = 32'h0000_0000;
        else if (er >= 10'sd255)
            r = {s, 8'hFF, 23'd0};
        else
            r = {s, er[7:0], mr[22:0]};
        return r;
    endfunction

    // Single-cycle binary32 add with denormal flush-to-zero.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic              sa, sb, sx, sy;
        logic [7:0]        ea, eb, ex, ey, d;
        logic [22:0]       fa, fb;
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [26:0]       mx, my, ys, m;
        logic [53:0]       wide;
        logic [5:0]        dc;
        logic [27:0]       sum;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic              found;
        logic [31:0]       r;

        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31]; eb = b[30:23]; fb = b[22:0];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);

        r = 32'h0000_0000;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            r = QNAN;
        end else if (a_inf) begin
            r = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            r = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            // only (-0)+(-0) keeps the negative sign
            r = {sa & sb, 31'd0};
        end else if (a_zero) begin
            r = b;
        end else if (b_zero) begin
            r = a;
        end else begin
            // x is the operand of larger magnitude; it sets the result sign
            if ({ea, fa} >= {eb, fb}) begin
                sx = sa; ex = ea; mx = {1'b1, fa, 3'b000};
                sy = sb; ey = eb; my = {1'b1, fb, 3'b000};
            end else begin
                sx = sb; ex = eb; mx = {1'b1, fb, 3'b000};
                sy = sa; ey = ea; my = {1'b1, fa, 3'b000};
            end
            d    = ex - ey;
            dc   = (d > 8'd27) ? 6'd27 : d[5:0];
            wide = {my, 27'd0} >> dc;
            // everything shifted past the guard/round bits folds into sticky
            ys   = wide[53:27] | {26'd0, |wide[26:0]};
            e    = $signed({2'b00, ex});
            if (sx == sy) begin
                sum = {1'b0, mx} + {1'b0, ys};
                if (sum[27]) begin
                    m = sum[27:1] | {26'd0, sum[0]};
                    e = e + 10'sd1;
                end else begin
                    m = sum[26:0];
                end
            end else begin
                sum   = {1'b0, mx} - {1'b0, ys};
                m     = sum[26:0];
                lz    = 5'd0;
                found = 1'b0;
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (m[i]) found = 1'b1;
                        else      lz    = lz + 5'd1;
                    end
                end
                m = m << lz;
                e = e - $signed({5'b00000, lz});
            end
            r = round_pack(sx, e, m);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dcnt  <= '0;
            scnt  <= '0;
            acc   <= 32'h0000_0000;
        end else if (run) begin
            // a run restarts the unit from any state, even when not running
            acc  <= 32'h0000_0000;
            dcnt <= delay0;
            scnt <= len;
            if (len == '0)
                state <= DONE;
            else if (delay0 == '0)
                state <= ACC;
            else
                state <= WAIT;
        end else if (running) begin
            case (state)
                WAIT: begin
                    dcnt <= dcnt - 1'b1;
                    if (dcnt <= 1) state <= ACC;
                end
                ACC: begin
                    acc  <= fadd(acc, in0);
                    scnt <= scnt - 1'b1;
                    if (scnt <= 1) state <= DONE;
                end
                default: ;
            endcase
        end
    end

    assign done = (state == IDLE) || (state == DONE);
    assign out0 = acc;

endmodule
